// File: rtl/dcm_seq_pkg.sv
// -----------------------------------------------------------------------------
// dcm_seq_pkg
// Shared types and default constants for the DCM lock sequencer.
//   state_t      : sequencer state encoding (FAIL only reachable when
//                  DCM_SEQ_RETRY_LIMIT_EN is defined)
//   DEF_*        : default parameter values for dcm_lock_sequencer
// -----------------------------------------------------------------------------
package dcm_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    localparam int unsigned DEF_RESET_CYCLES  = 4;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
    localparam int unsigned DEF_STABLE_CYCLES = 256;
    localparam int unsigned DEF_CNT_WIDTH     = 16;
    localparam int unsigned DEF_RETRY_WIDTH   = 8;
    localparam int unsigned DEF_MAX_RETRIES   = 3;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchronizer, synchronous active-high reset to 0.
//   clock    in  destination clock
//   reset    in  synchronous reset, active-high
//   i_async  in  asynchronous input
//   o_sync   out synchronized output (2-edge latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/dcm_lock_sequencer.sv
// -----------------------------------------------------------------------------
// dcm_lock_sequencer
// Pulses the DCM reset after power-up, waits for lock, qualifies lock over a
// stability window and only then releases the system reset. Lock timeout or
// lock loss in RUN re-pulses the DCM and counts a retry.
// Optional macro DCM_SEQ_RETRY_LIMIT_EN: adds a terminal FAIL state entered
// when the retry count would reach MaxRetries (left only via reset).
//   clock        in  raw board clock
//   reset        in  synchronous reset, active-high
//   dcm_locked   in  DCM LOCKED, asynchronous
//   dcm_reset    out DCM RST drive (registered)
//   sys_reset    out system reset, active-high (registered)
//   ready        out high only in RUN (registered)
//   retry_count  out saturating count of timeouts plus lock losses
//   fail         out retry limit exhausted (0 unless feature enabled)
// -----------------------------------------------------------------------------
import dcm_seq_pkg::*;

module dcm_lock_sequencer #(
    parameter int unsigned ResetCycles  = DEF_RESET_CYCLES,
    parameter int unsigned LockTimeout  = DEF_LOCK_TIMEOUT,
    parameter int unsigned StableCycles = DEF_STABLE_CYCLES,
    parameter int unsigned CntWidth     = DEF_CNT_WIDTH,
    parameter int unsigned RetryWidth   = DEF_RETRY_WIDTH
`ifdef DCM_SEQ_RETRY_LIMIT_EN
   ,parameter int unsigned MaxRetries   = DEF_MAX_RETRIES
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dcm_locked,
    output logic                  dcm_reset,
    output logic                  sys_reset,
    output logic                  ready,
    output logic [RetryWidth-1:0] retry_count,
    output logic                  fail
);

    state_t                r_state;
    logic [CntWidth-1:0]   r_cnt;
    logic                  r_dcm_reset;
    logic                  r_sys_reset;
    logic                  r_ready;
    logic [RetryWidth-1:0] r_retry_count;

    logic                  w_locked_s;
    logic [RetryWidth-1:0] w_retry_next;
    state_t                w_retry_state;

    sync_2ff u_sync_locked (
        .clock   (clock),
        .reset   (reset),
        .i_async (dcm_locked),
        .o_sync  (w_locked_s)
    );

    // Saturating increment used on every retry transition.
    assign w_retry_next = (r_retry_count == '1) ? r_retry_count
                                                : r_retry_count + RetryWidth'(1);

    // Destination of a retry: HOLD, or FAIL once the limit would be reached.
`ifdef DCM_SEQ_RETRY_LIMIT_EN
    logic r_fail;
    assign w_retry_state = (w_retry_next == RetryWidth'(MaxRetries)) ? FAIL : HOLD;
`else
    assign w_retry_state = HOLD;
`endif

    // Sequencer FSM; outputs only change on transitions, so each register
    // always matches the decode of the state it is entering.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= HOLD;
            r_cnt         <= '0;
            r_dcm_reset   <= 1'b1;
            r_sys_reset   <= 1'b1;
            r_ready       <= 1'b0;
            r_retry_count <= '0;
`ifdef DCM_SEQ_RETRY_LIMIT_EN
            r_fail        <= 1'b0;
`endif
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == CntWidth'(ResetCycles - 1)) begin
                        r_state     <= WAIT_LOCK;
                        r_cnt       <= '0;
                        r_dcm_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CntWidth'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Lock wins over a simultaneous timeout.
                    if (w_locked_s) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CntWidth'(LockTimeout - 1)) begin
                        r_state       <= w_retry_state;
                        r_cnt         <= '0;
                        r_retry_count <= w_retry_next;
                        r_dcm_reset   <= 1'b1;
`ifdef DCM_SEQ_RETRY_LIMIT_EN
                        r_fail        <= (w_retry_state == FAIL);
`endif
                    end else begin
                        r_cnt <= r_cnt + CntWidth'(1);
                    end
                end
                STABLE: begin
                    // A lock glitch restarts qualification without a DCM pulse.
                    if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == CntWidth'(StableCycles - 1)) begin
                        r_state     <= RUN;
                        r_sys_reset <= 1'b0;
                        r_ready     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CntWidth'(1);
                    end
                end
                RUN: begin
                    if (!w_locked_s) begin
                        r_state       <= w_retry_state;
                        r_cnt         <= '0;
                        r_retry_count <= w_retry_next;
                        r_dcm_reset   <= 1'b1;
                        r_sys_reset   <= 1'b1;
                        r_ready       <= 1'b0;
`ifdef DCM_SEQ_RETRY_LIMIT_EN
                        r_fail        <= (w_retry_state == FAIL);
`endif
                    end
                end
`ifdef DCM_SEQ_RETRY_LIMIT_EN
                FAIL: begin
                    r_state <= FAIL;
                end
`endif
                default: begin
                    r_state     <= HOLD;
                    r_cnt       <= '0;
                    r_dcm_reset <= 1'b1;
                    r_sys_reset <= 1'b1;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign dcm_reset   = r_dcm_reset;
    assign sys_reset   = r_sys_reset;
    assign ready       = r_ready;
    assign retry_count = r_retry_count;
`ifdef DCM_SEQ_RETRY_LIMIT_EN
    assign fail        = r_fail;
`else
    assign fail        = 1'b0;
`endif

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dcm_lock_sequencer
// Directed bench for dcm_lock_sequencer with ResetCycles=4, LockTimeout=16,
// StableCycles=8 (MaxRetries=3 when DCM_SEQ_RETRY_LIMIT_EN is defined).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_dcm_lock_sequencer;

    logic       clock;
    logic       reset;
    logic       dcm_locked;
    logic       dcm_reset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] retry_count;
    logic       fail;

    int checks   = 0;
    int failures = 0;

    dcm_lock_sequencer #(
        .ResetCycles  (4),
        .LockTimeout  (16),
        .StableCycles (8),
        .CntWidth     (16),
        .RetryWidth   (8)
`ifdef DCM_SEQ_RETRY_LIMIT_EN
       ,.MaxRetries   (3)
`endif
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dcm_locked  (dcm_locked),
        .dcm_reset   (dcm_reset),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .retry_count (retry_count),
        .fail        (fail)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts consecutive samples (including the current one) at the given dcm_reset level.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (dcm_reset === lvl && n < 200) begin
            n++;
            tick();
        end
    endtask

    int   n;
    logic dcm_seen;

    initial begin
        reset      = 1'b1;
        dcm_locked = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_dcm_reset", 32'(dcm_reset), 1);
        check("rst_sys_reset", 32'(sys_reset), 1);
        check("rst_ready",     32'(ready), 0);
        check("rst_retry",     32'(retry_count), 0);
        check("rst_fail",      32'(fail), 0);

        // Power-up DCM reset pulse
        reset = 1'b0;
        measure(1'b1, n);
        check("pwrup_pulse_width", 32'(n), 4);
        check("pwrup_sys_reset", 32'(sys_reset), 1);

        // Lock acquire: release after E+10
        dcm_locked = 1'b1;
        repeat (10) tick();
        check("acq_sys_reset_e9", 32'(sys_reset), 1);
        tick();
        check("acq_sys_reset_e10", 32'(sys_reset), 0);
        check("acq_ready", 32'(ready), 1);
        check("acq_retry", 32'(retry_count), 0);
        check("acq_dcm_reset", 32'(dcm_reset), 0);

        // Lock loss in RUN: re-assert after E+2
        dcm_locked = 1'b0;
        tick();
        tick();
        check("loss_sys_reset_e1", 32'(sys_reset), 0);
        tick();
        check("loss_sys_reset_e2", 32'(sys_reset), 1);
        check("loss_dcm_reset_e2", 32'(dcm_reset), 1);
        check("loss_ready_e2", 32'(ready), 0);
        check("loss_retry", 32'(retry_count), 1);
        measure(1'b1, n);
        check("loss_pulse_width", 32'(n), 4);

        // Lock rises in the same cycle the timeout expires: lock wins
        repeat (13) tick();
        dcm_locked = 1'b1;
        dcm_seen   = 1'b0;
        repeat (10) begin
            tick();
            dcm_seen |= dcm_reset;
        end
        check("simul_sys_reset_w23", 32'(sys_reset), 1);
        tick();
        dcm_seen |= dcm_reset;
        check("simul_sys_reset_w24", 32'(sys_reset), 0);
        check("simul_no_dcm_pulse", 32'(dcm_seen), 0);
        check("simul_retry", 32'(retry_count), 1);

        // Lock glitch in STABLE: back to WAIT_LOCK, no pulse, no retry
        dcm_locked = 1'b0;
        repeat (3) tick();
        check("glitch_pre_retry", 32'(retry_count), 2);
        measure(1'b1, n);
        check("glitch_pre_pulse", 32'(n), 4);
        dcm_locked = 1'b1;
        repeat (3) tick();
        dcm_locked = 1'b0;
        tick();
        dcm_locked = 1'b1;
        dcm_seen   = 1'b0;
        repeat (10) begin
            tick();
            dcm_seen |= dcm_reset;
        end
        check("glitch_sys_reset_e13", 32'(sys_reset), 1);
        tick();
        dcm_seen |= dcm_reset;
        check("glitch_sys_reset_e14", 32'(sys_reset), 0);
        check("glitch_no_dcm_pulse", 32'(dcm_seen), 0);
        check("glitch_retry", 32'(retry_count), 2);

`ifdef DCM_SEQ_RETRY_LIMIT_EN
        // Mid-operation reset from RUN, then retry limit
        dcm_locked = 1'b0;
        reset      = 1'b1;
        tick();
        check("midrst_sys_reset", 32'(sys_reset), 1);
        check("midrst_dcm_reset", 32'(dcm_reset), 1);
        check("midrst_retry", 32'(retry_count), 0);
        reset = 1'b0;
        repeat (59) tick();
        check("limit_fail_e59", 32'(fail), 0);
        tick();
        check("limit_fail_e60", 32'(fail), 1);
        check("limit_dcm_reset", 32'(dcm_reset), 1);
        check("limit_sys_reset", 32'(sys_reset), 1);
        check("limit_ready", 32'(ready), 0);
        check("limit_retry", 32'(retry_count), 3);
        repeat (30) tick();
        check("limit_fail_held", 32'(fail), 1);
        check("limit_dcm_held", 32'(dcm_reset), 1);
        reset = 1'b1;
        tick();
        check("limit_rst_fail", 32'(fail), 0);
        check("limit_rst_dcm_reset", 32'(dcm_reset), 1);
        check("limit_rst_sys_reset", 32'(sys_reset), 1);
        check("limit_rst_ready", 32'(ready), 0);
        check("limit_rst_retry", 32'(retry_count), 0);
        reset = 1'b0;
`else
        // Lock held low: 4 high / 16 low repeating, retries counting up
        dcm_locked = 1'b0;
        repeat (3) tick();
        check("timeout_retry_3", 32'(retry_count), 3);
        measure(1'b1, n);
        check("timeout_high_1", 32'(n), 4);
        measure(1'b0, n);
        check("timeout_low_1", 32'(n), 16);
        check("timeout_retry_4", 32'(retry_count), 4);
        measure(1'b1, n);
        check("timeout_high_2", 32'(n), 4);
        measure(1'b0, n);
        check("timeout_low_2", 32'(n), 16);
        check("timeout_retry_5", 32'(retry_count), 5);
        check("timeout_fail", 32'(fail), 0);

        // Saturation at all-ones
        n = 0;
        while (retry_count !== 8'hFF && n < 8000) begin
            n++;
            tick();
        end
        check("sat_reached", 32'(retry_count), 255);
        measure(1'b1, n);
        measure(1'b0, n);
        check("sat_low_period", 32'(n), 16);
        check("sat_no_wrap", 32'(retry_count), 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcm_lock_sequencer.md
Name: dcm_lock_sequencer

Overview:
Controls the on-chip clock manager's reset and lock handshake, driving the DCM reset input and consuming its lock output.
- Pulses the DCM reset for a minimum width after power-up.
- Waits for lock, then requires lock to stay high for a qualification window before releasing the system reset.
- Re-runs the sequence on lock timeout or lock loss.
- Sits between the board reset/clock input and the clock-manager wrapper; its sys_reset feeds all downstream logic.

Parameters:
- ResetCycles, 4, DCM reset pulse width in cycles (≥3).
- LockTimeout, 4096, cycles allowed in WAIT_LOCK before re-pulsing the DCM.
- StableCycles, 256, consecutive synchronized-lock cycles required before release.
- CntWidth, 16, width of the shared state counter; must hold max(ResetCycles, LockTimeout, StableCycles) − 1.
- RetryWidth, 8, width of retry_count.
- MaxRetries, 3, retry limit (used only with the optional feature).

Ports:
- clock  in  1  Sequencer clock. This is the raw board clock, not a DCM output.
- reset  in  1  Reset, synchronous, active-high; clock clock.
- dcm_locked  in  1  DCM LOCKED, asynchronous to clock.
- dcm_reset  out  1  DCM RST drive, registered.
- sys_reset  out  1  System reset, registered, active-high.
- ready  out  1  High only in RUN, registered.
- retry_count  out  RetryWidth  Count of timeouts plus lock losses, saturating.
- fail  out  1  Retry limit exhausted; tied 0 unless the feature is enabled.

Behaviour:
- dcm_locked passes through a 2-flop synchronizer to give locked_s. Latency is 2 edges; the synchronizer flops reset to 0.
- Reset values: state=HOLD, cnt=0, dcm_reset=1, sys_reset=1, ready=0, retry_count=0, fail=0. A reset mid-operation returns to these values from any state at the next edge.
- All outputs are registered and decoded from the next state.
- State HOLD:
  - dcm_reset=1, cnt increments each cycle.
  - When cnt==ResetCycles−1: go to WAIT_LOCK, cnt=0.
  - dcm_reset is therefore high for exactly ResetCycles cycles after reset deasserts.
- State WAIT_LOCK:
  - dcm_reset=0.
  - If locked_s: go to STABLE, cnt=0.
  - Else if cnt==LockTimeout−1: go to HOLD, cnt=0, retry_count+1.
  - Else cnt+1.
- State STABLE:
  - If !locked_s: go to WAIT_LOCK, cnt=0. A lock glitch does not re-pulse the DCM and does not count as a retry.
  - Else if cnt==StableCycles−1: go to RUN.
  - Else cnt+1.
- State RUN:
  - sys_reset=0, ready=1.
  - If !locked_s: go to HOLD, cnt=0, retry_count+1. sys_reset and dcm_reset re-assert at the same edge.
- sys_reset=1 in every state except RUN; ready == !sys_reset at all times.
- Release latency: if dcm_locked rises and is first sampled at edge E, sys_reset falls after edge E+2+StableCycles.
- retry_count saturates at all-ones and never wraps.
- Simultaneous events: a timeout and a lock rise in the same WAIT_LOCK cycle resolve to lock (go to STABLE).

Optional Feature:
Macro DCM_SEQ_RETRY_LIMIT_EN.
- Defined: adds state FAIL.
  - A transition to HOLD that would make retry_count == MaxRetries goes to FAIL instead.
  - FAIL holds dcm_reset=1, sys_reset=1, ready=0, fail=1.
  - FAIL is left only via reset.
- Undefined: retries forever; fail is tied 0; FAIL is not synthesized.

Decomposition:
- Package dcm_seq_pkg holds the state enum (HOLD, WAIT_LOCK, STABLE, RUN, FAIL) and the default constants for ResetCycles, LockTimeout and StableCycles.
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer with synchronous reset to 0.

Test Plan (ResetCycles=4, LockTimeout=16, StableCycles=8):
1. Release reset with dcm_locked=0 → dcm_reset=1 for exactly 4 cycles, then 0; sys_reset stays 1.
2. dcm_locked rises, first sampled at edge E, and stays high → sys_reset=0 and ready=1 after edge E+10; retry_count=0.
3. dcm_locked held 0 → dcm_reset re-pulses every 20 cycles (4 high, 16 low); retry_count goes 1, 2, 3…
4. In RUN, drop dcm_locked at edge E → sys_reset=1 and dcm_reset=1 after edge E+2; retry_count +1; the full sequence repeats.
5. In STABLE, apply a 1-cycle low glitch on dcm_locked → return to WAIT_LOCK with no dcm_reset pulse and no retry increment; release delayed by a full 8-cycle window.
6. With DCM_SEQ_RETRY_LIMIT_EN and MaxRetries=3, hold dcm_locked=0 → fail=1 after the 3rd timeout, dcm_reset held 1; assert reset → all outputs return to reset values.
